// File: rtl/iob_axistream_in_drain.sv
// rtl/iob_axistream_in_drain.sv - drains the AXI-Stream input FIFO into consecutive memory words
// Stops on word count, on TLAST (when enabled) or on abort; a word already popped is always written.
module iob_axistream_in_drain #(
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  max_len_i,
  input  logic              stop_on_last_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  count_o,
  output logic              last_seen_o,
  output logic              trunc_o,
  output logic              aborted_o,
  output logic              fifo_ren_o,
  input  logic [DATA_W-1:0] fifo_rdata_i,
  input  logic              fifo_rvalid_i,
  input  logic              fifo_empty_i,
  input  logic              fifo_last_i,
  input  logic [STRB_W-1:0] fifo_rstrb_i,
  output logic              mem_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [STRB_W-1:0] mem_wstrb_o,
  input  logic              mem_ready_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_count;
  logic              r_last_seen;
  logic              r_trunc;
  logic              r_aborted;
  logic              r_abort_pend;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              r_last;

  logic [LEN_W-1:0]  w_count_inc;
  logic [ADDR_W-1:0] w_addr_inc;
  logic              w_abort;

  assign w_count_inc = r_count + {{(LEN_W-1){1'b0}}, 1'b1};
  assign w_addr_inc  = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
  // an abort raised in the same cycle as the handshake still ends the transfer
  assign w_abort     = r_abort_pend | abort_i;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_count      <= '0;
      r_last_seen  <= 1'b0;
      r_trunc      <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_last       <= 1'b0;
    end else if (cke_i) begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_count      <= '0;
            r_last_seen  <= 1'b0;
            r_trunc      <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
            if (max_len_i == '0) begin
              r_state <= S_DONE;
            end else begin
              r_addr  <= base_addr_i;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (abort_i) begin
            r_aborted <= 1'b1;
            r_state   <= S_DONE;
          end else if (!fifo_empty_i) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort_i) r_abort_pend <= 1'b1;
          if (fifo_rvalid_i) begin
            r_wdata <= fifo_rdata_i;
            r_wstrb <= fifo_rstrb_i;
            r_last  <= fifo_last_i;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (mem_ready_i) begin
            r_addr  <= w_addr_inc;
            r_count <= w_count_inc;
            if (w_abort) begin
              r_aborted <= 1'b1;
              r_state   <= S_DONE;
            end else if (stop_on_last_i && r_last) begin
              r_last_seen <= 1'b1;
              r_state     <= S_DONE;
            end else if (w_count_inc == max_len_i) begin
              r_trunc     <= stop_on_last_i & ~r_last;
              r_last_seen <= r_last;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_REQ;
            end
          end else if (abort_i) begin
            r_abort_pend <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // the read is withheld when aborting from REQ so no popped word is dropped
  assign fifo_ren_o  = (r_state == S_REQ) & ~fifo_empty_i & ~abort_i;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign mem_valid_o = (r_state == S_WRITE);
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_wstrb_o = r_wstrb;
  assign count_o     = r_count;
  assign last_seen_o = r_last_seen;
  assign trunc_o     = r_trunc;
  assign aborted_o   = r_aborted;

endmodule

// File: tb/tb_iob_axistream_in_drain.sv
// tb/tb_iob_axistream_in_drain.sv - scoreboard bench for the FIFO drain controller
// A FIFO model feeds the DUT; expected memory writes are queued with the stimulus and checked on handshake.
module tb_iob_axistream_in_drain;

  logic        clk = 1'b0;
  logic        cke = 1'b1;
  logic        arst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] base_addr = '0;
  logic [15:0] max_len = '0;
  logic        stop_on_last = 1'b0;
  logic        busy, done, last_seen, trunc, aborted, fifo_ren;
  logic [15:0] count;
  logic [31:0] fifo_rdata = '0;
  logic        fifo_rvalid = 1'b0;
  logic        fifo_empty;
  logic        fifo_last = 1'b0;
  logic [3:0]  fifo_rstrb = '0;
  logic        mem_valid;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b1;

  typedef struct { logic [31:0] d; logic [3:0] s; logic l; } fifo_t;
  typedef struct { logic [23:0] a; logic [31:0] d; logic [3:0] s; } wr_t;

  fifo_t fifo_q[$];
  wr_t   exp_q[$];
  int    fifo_cnt = 0;
  logic  force_empty = 1'b0;
  int    n_ren = 0;
  int    n_wr = 0;
  int    n_tests = 0;
  int    n_fail = 0;

  assign fifo_empty = force_empty | (fifo_cnt == 0);

  iob_axistream_in_drain dut (
    .clk_i(clk), .cke_i(cke), .arst_i(arst), .start_i(start), .abort_i(abort),
    .base_addr_i(base_addr), .max_len_i(max_len), .stop_on_last_i(stop_on_last),
    .busy_o(busy), .done_o(done), .count_o(count), .last_seen_o(last_seen),
    .trunc_o(trunc), .aborted_o(aborted), .fifo_ren_o(fifo_ren),
    .fifo_rdata_i(fifo_rdata), .fifo_rvalid_i(fifo_rvalid), .fifo_empty_i(fifo_empty),
    .fifo_last_i(fifo_last), .fifo_rstrb_i(fifo_rstrb),
    .mem_valid_o(mem_valid), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_wstrb_o(mem_wstrb), .mem_ready_i(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO read port: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (fifo_ren) begin
      fifo_t e;
      n_ren++;
      e = '{d: 32'h0, s: 4'h0, l: 1'b0};
      if (fifo_q.size() > 0) e = fifo_q.pop_front();
      fifo_cnt    = fifo_q.size();
      fifo_rdata  <= e.d;
      fifo_rstrb  <= e.s;
      fifo_last   <= e.l;
      fifo_rvalid <= 1'b1;
    end else begin
      fifo_rvalid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mem_valid && mem_ready && !arst) begin
      wr_t w;
      n_wr++;
      n_tests++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_write observed_addr=%0h expected=none", mem_addr);
      end
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(w.a));
        chk("wr_data", mem_wdata, w.d);
        chk("wr_strb", 32'(mem_wstrb), 32'(w.s));
      end
    end
  end

  task automatic push_word(input logic [31:0] d, input logic [3:0] s, input logic l);
    fifo_q.push_back('{d: d, s: s, l: l});
    fifo_cnt = fifo_q.size();
  endtask

  task automatic expect_wr(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_q.push_back('{a: a, d: d, s: s});
  endtask

  task automatic flush_fifo();
    fifo_q.delete();
    fifo_cnt = 0;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    logic got;
    got = 1'b0;
    cyc = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_timeout", 32'(got), 32'd1);
  endtask

  task automatic after_done();
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_low_t2", 32'(busy), 32'd0);
    chk("exp_q_drained", exp_q.size(), 0);
  endtask

  task automatic wait_valid();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("valid_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    int cyc;
    int r0;
    logic [23:0] a0;
    logic [31:0] d0;
    logic got;

    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_ren", 32'(fifo_ren), 32'd0);
    chk("rst_flags", {29'd0, last_seen, trunc, aborted}, 32'd0);
    @(posedge clk); #1 arst = 1'b0;

    // single word, best-case latency
    base_addr = 24'h10; max_len = 16'd1; stop_on_last = 1'b0;
    push_word(32'hDEADBEEF, 4'hF, 1'b0);
    expect_wr(24'h10, 32'hDEADBEEF, 4'hF);
    r0 = n_ren;
    do_start();
    wait_done(cyc);
    chk("single_latency", cyc, 4);
    chk("single_count", 32'(count), 32'd1);
    chk("single_trunc", 32'(trunc), 32'd0);
    chk("single_ren", n_ren - r0, 1);
    after_done();

    // packet terminated by LAST
    base_addr = 24'h100; max_len = 16'd8; stop_on_last = 1'b1;
    push_word(32'h11111111, 4'hF, 1'b0);
    push_word(32'h22222222, 4'h3, 1'b0);
    push_word(32'h33333333, 4'h1, 1'b1);
    expect_wr(24'h100, 32'h11111111, 4'hF);
    expect_wr(24'h101, 32'h22222222, 4'h3);
    expect_wr(24'h102, 32'h33333333, 4'h1);
    r0 = n_ren;
    do_start();
    wait_done(cyc);
    chk("last_seen", 32'(last_seen), 32'd1);
    chk("last_count", 32'(count), 32'd3);
    chk("last_ren", n_ren - r0, 3);
    chk("last_trunc", 32'(trunc), 32'd0);
    after_done();

    // truncation at max_len without LAST
    base_addr = 24'h200; max_len = 16'd2;
    for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i), 4'hF, 1'b0);
    expect_wr(24'h200, 32'hA0, 4'hF);
    expect_wr(24'h201, 32'hA1, 4'hF);
    do_start();
    wait_done(cyc);
    chk("trunc_flag", 32'(trunc), 32'd1);
    chk("trunc_count", 32'(count), 32'd2);
    chk("trunc_fifo_left", fifo_cnt, 2);
    after_done();
    flush_fifo();

    // write backpressure: outputs stable, no reads while stalled
    base_addr = 24'h300; max_len = 16'd2; stop_on_last = 1'b0; mem_ready = 1'b0;
    push_word(32'hCAFE0001, 4'hC, 1'b0);
    push_word(32'hCAFE0002, 4'h5, 1'b0);
    expect_wr(24'h300, 32'hCAFE0001, 4'hC);
    expect_wr(24'h301, 32'hCAFE0002, 4'h5);
    do_start();
    wait_valid();
    a0 = mem_addr; d0 = mem_wdata; r0 = n_ren;
    chk("bp_addr0", 32'(a0), 32'h300);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_valid", 32'(mem_valid), 32'd1);
      chk("bp_addr_stable", 32'(mem_addr), 32'(a0));
      chk("bp_data_stable", mem_wdata, d0);
    end
    chk("bp_no_ren", n_ren - r0, 0);
    @(posedge clk); #1 mem_ready = 1'b1;
    wait_done(cyc);
    chk("bp_count", 32'(count), 32'd2);
    after_done();

    // FIFO empty: controller waits in REQ without reading
    base_addr = 24'h400; max_len = 16'd1; force_empty = 1'b1;
    push_word(32'h0BADF00D, 4'hF, 1'b0);
    expect_wr(24'h400, 32'h0BADF00D, 4'hF);
    r0 = n_ren;
    do_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("empty_busy", 32'(busy), 32'd1);
      chk("empty_ren", 32'(fifo_ren), 32'd0);
      @(posedge clk); #1;
    end
    chk("empty_no_read", n_ren - r0, 0);
    force_empty = 1'b0;
    wait_done(cyc);
    chk("empty_count", 32'(count), 32'd1);
    after_done();

    // abort while waiting for word 2
    base_addr = 24'h500; max_len = 16'd8;
    for (int i = 0; i < 4; i++) push_word(32'hB0 + 32'(i), 4'hF, 1'b0);
    expect_wr(24'h500, 32'hB0, 4'hF);
    expect_wr(24'h501, 32'hB1, 4'hF);
    r0 = n_ren;
    do_start();
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fifo_ren && (n_ren - r0) == 1) begin
        got = 1'b1;
        break;
      end
    end
    chk("abort_wait_found", 32'(got), 32'd1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done(cyc);
    chk("abort_wait_flag", 32'(aborted), 32'd1);
    chk("abort_wait_count", 32'(count), 32'd2);
    chk("abort_wait_fifo_left", fifo_cnt, 2);
    after_done();
    flush_fifo();

    // max_len zero clears prior status and finishes with no traffic
    max_len = 16'd0;
    r0 = n_ren;
    d0 = 32'(n_wr);
    do_start();
    wait_done(cyc);
    chk("len0_latency", cyc, 1);
    chk("len0_count", 32'(count), 32'd0);
    chk("len0_aborted_clr", 32'(aborted), 32'd0);
    chk("len0_no_ren", n_ren - r0, 0);
    chk("len0_no_wr", n_wr, int'(d0));
    after_done();

    // abort in REQ: done next cycle, no read
    max_len = 16'd4; force_empty = 1'b1;
    r0 = n_ren;
    do_start();
    abort = 1'b1;
    wait_done(cyc);
    abort = 1'b0;
    chk("abort_req_latency", cyc, 2);
    chk("abort_req_flag", 32'(aborted), 32'd1);
    chk("abort_req_count", 32'(count), 32'd0);
    chk("abort_req_no_ren", n_ren - r0, 0);
    after_done();
    force_empty = 1'b0;

    // address wrap at the top of the word space
    base_addr = 24'hFFFFFF; max_len = 16'd2; stop_on_last = 1'b0;
    push_word(32'h5A5A0001, 4'hF, 1'b0);
    push_word(32'h5A5A0002, 4'hF, 1'b1);
    expect_wr(24'hFFFFFF, 32'h5A5A0001, 4'hF);
    expect_wr(24'h000000, 32'h5A5A0002, 4'hF);
    do_start();
    wait_done(cyc);
    chk("wrap_count", 32'(count), 32'd2);
    chk("wrap_trunc", 32'(trunc), 32'd0);
    chk("wrap_last_report", 32'(last_seen), 32'd1);
    after_done();

    // asynchronous reset in the middle of a stalled write
    base_addr = 24'h600; max_len = 16'd1; mem_ready = 1'b0;
    push_word(32'h77777777, 4'hF, 1'b0);
    do_start();
    wait_valid();
    #1 arst = 1'b1;
    #1;
    chk("arst_valid", 32'(mem_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_addr", 32'(mem_addr), 32'd0);
    chk("arst_wdata", mem_wdata, 32'd0);
    chk("arst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    @(posedge clk); #1 arst = 1'b0; mem_ready = 1'b1;
    flush_fifo();
    chk("arst_no_pending_exp", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_axistream_in_drain.md
# iob_axistream_in_drain

Drain controller for the AXI-Stream input FIFO. It sequences word reads from the FIFO's CPU-side read port and writes each word, with its byte strobe, to consecutive word addresses of a memory write port. Transfers stop on a programmed word count, on the packet's TLAST or on a software abort. It sits between the axistream_in core and a system memory/bus master, replacing CPU polling of DATA/LAST/RSTRB.

## Interface
- DATA_W, 32, FIFO read word and memory write data width
- STRB_W, DATA_W/8, strobe width; equals the FIFO RSTRB width
- ADDR_W, 24, memory word-address width
- LEN_W, 16, transfer-length and word-counter width

Ports:
- clk_i  in  1  system clock; all state on posedge
- cke_i  in  1  clock enable; when low, every register holds
- arst_i  in  1  asynchronous, active-high reset
- start_i  in  1  start pulse; sampled only in IDLE
- abort_i  in  1  abort request
- base_addr_i  in  ADDR_W  first word address
- max_len_i  in  LEN_W  maximum number of words to transfer
- stop_on_last_i  in  1  end the transfer after the word carrying LAST
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse
- count_o  out  LEN_W  words written in the current or last transfer
- last_seen_o  out  1  transfer ended on LAST
- trunc_o  out  1  max_len reached with stop_on_last_i set and no LAST seen
- aborted_o  out  1  transfer ended by abort
- fifo_ren_o  out  1  FIFO read strobe (single-cycle pulse)
- fifo_rdata_i  in  DATA_W  FIFO read data
- fifo_rvalid_i  in  1  FIFO read data valid
- fifo_empty_i  in  1  FIFO empty
- fifo_last_i  in  1  LAST flag of the word being read
- fifo_rstrb_i  in  STRB_W  strobe of the word being read
- mem_valid_o  out  1  write request
- mem_addr_o  out  ADDR_W  write word address
- mem_wdata_o  out  DATA_W  write data
- mem_wstrb_o  out  STRB_W  write byte strobe
- mem_ready_i  in  1  write accepted

## Operation
- The FSM has five states: IDLE, REQ, WAIT, WRITE, DONE.
- **IDLE**
  - On start_i with max_len_i==0: go to DONE; count_o=0 and all flags are cleared.
  - On start_i otherwise: addr=base_addr_i, count=0, clear last_seen/trunc/aborted and the abort-pending flag; go to REQ.
  - start_i in any other state is ignored.
- **REQ**
  - fifo_ren_o = ~fifo_empty_i. If not empty, go to WAIT; otherwise stay in REQ.
  - abort_i in REQ: set aborted; go to DONE with no FIFO read.
- **WAIT**
  - fifo_ren_o=0.
  - On fifo_rvalid_i: latch rdata, rstrb and last into the output registers; go to WRITE.
- **WRITE**
  - mem_valid_o=1 with the latched data and strobe, and mem_addr_o=addr. These outputs are stable until mem_ready_i.
  - On mem_ready_i: addr+1 (wraps modulo 2^ADDR_W) and count+1. Then take the first matching action below:
    - abort pending: aborted=1, go to DONE
    - stop_on_last_i & latched last: last_seen=1, go to DONE
    - count+1==max_len_i: trunc = stop_on_last_i & ~latched last; go to DONE
    - otherwise: go to REQ
- **DONE**: done_o=1 for one cycle, then go to IDLE.
- abort_i seen in WAIT or WRITE sets abort-pending. The word already popped is still written, so no data is lost.
- When stop_on_last_i=0, LAST is ignored for termination. last_seen_o still reports whether the final word carried LAST.
- count_o and the status flags hold after DONE until the next accepted start.
- Reset values: state=IDLE. All outputs are 0, including addr, count and the latched data/strobe.

## Timing
- Moore outputs:
  - busy_o = (state != IDLE)
  - done_o = (state == DONE)
  - mem_valid_o = (state == WRITE)
- fifo_ren_o is the only output with a combinational input term: REQ & ~fifo_empty_i.
- fifo_ren_o is low for at least 2 cycles between pulses, which satisfies the FIFO's rising-edge read detect.
- fifo_rvalid_i is expected the cycle after fifo_ren_o. WAIT holds indefinitely until fifo_rvalid_i arrives.
- Best case with FIFO non-empty and mem_ready_i high:
  - start_i at cycle 0 → REQ/ren at cycle 1 → WAIT at cycle 2 → WRITE at cycle 3 → next REQ at cycle 4.
  - This gives 3 cycles per word.
- After the final handshake in cycle t: done_o is high in cycle t+1 and busy_o is low from t+2.
- Every mem_ready_i cycle of backpressure adds exactly one cycle.
- cke_i low freezes all state and counters; outputs hold.
- arst_i mid-transfer returns to IDLE immediately. mem_valid_o is dropped without a handshake; this is allowed only under reset.

## Test plan
- **Single word:** base=0x10, max_len=1, FIFO holds 0xDEADBEEF with strb=0xF → one write to 0x10 of 0xDEADBEEF; done_o pulse; count_o=1; trunc_o=0.
- **Packet on LAST:** stop_on_last=1, max_len=8, FIFO holds 3 words with LAST on word 3 → 3 writes to base..base+2; last_seen_o=1; count_o=3; exactly 3 ren pulses.
- **Truncation:** stop_on_last=1, max_len=2, FIFO holds 4 words with no LAST → 2 writes; trunc_o=1; 2 words remain in the FIFO.
- **Backpressure and empty:**
  - Hold mem_ready_i low 5 cycles on word 1 → mem_addr/wdata stable for all 6 cycles; no ren during WRITE.
  - FIFO empty for 10 cycles → FSM stays in REQ with ren low.
- **Abort in WAIT:** abort_i in WAIT on word 2 of max_len=8 → word 2 still written; aborted_o=1; count_o=2.
- **Abort in REQ:** abort_i in REQ → DONE next cycle with no read.
- **Edge cases:**
  - base=2^ADDR_W-1 with 2 words → second write at address 0.
  - max_len=0 → done_o at cycle 1 with no traffic.
  - arst_i mid-WRITE → all outputs 0.
